// File: rtl/ahb_lite_sram_ctrl.sv
// AHB-Lite zero-wait SRAM slave with a one-entry posted-write buffer.
// Reads merge pending buffered bytes, so they never return stale SRAM data.
module ahb_lite_sram_ctrl #(
  parameter int HADDR_WIDTH = 32,
  parameter int HDATA_WIDTH = 32,
  parameter int MEM_AW      = 10
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic                     HSEL,
  input  logic [HADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]               HTRANS,
  input  logic                     HWRITE,
  input  logic [2:0]               HSIZE,
  input  logic [HDATA_WIDTH-1:0]   HWDATA,
  input  logic                     HREADY,
  output logic [HDATA_WIDTH-1:0]   HRDATA,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic [HDATA_WIDTH-1:0]   mem_wdata,
  output logic [HDATA_WIDTH/8-1:0] mem_be,
  output logic                     mem_we,
  output logic                     mem_re,
  input  logic [HDATA_WIDTH-1:0]   mem_rdata
);
  localparam int NB  = HDATA_WIDTH / 8;
  localparam int LB  = $clog2(NB);
  localparam int LBW = (LB > 0) ? LB : 1;

  // state    | meaning
  // ST_OK    | normal OKAY responses
  // ST_ERR1  | first ERROR cycle, HREADYOUT low
  // ST_ERR2  | second ERROR cycle, HREADYOUT high
  typedef enum logic [1:0] {ST_OK, ST_ERR1, ST_ERR2} state_t;
  state_t state, state_nxt;

  logic [MEM_AW-1:0]      addr_idx;
  logic [LBW-1:0]         addr_off;
  logic [LBW-1:0]         size_mask;
  logic [NB-1:0]          addr_be;
  logic                   size_ok, accept, rd_present, rd_issue;
  logic                   err_accept, stall, wr_done;
  logic                   dp_write, dp_read;
  logic [MEM_AW-1:0]      dp_idx;
  logic [NB-1:0]          dp_be;
  logic                   wbuf_valid;
  logic [MEM_AW-1:0]      wbuf_addr;
  logic [NB-1:0]          wbuf_be;
  logic [HDATA_WIDTH-1:0] wbuf_data;
  logic                   unused_bits;

  assign addr_idx    = HADDR[LB +: MEM_AW];
  assign addr_off    = (LB > 0) ? HADDR[LBW-1:0] : '0;
  assign size_ok     = (HSIZE <= 3'(LB));
  assign unused_bits = ^{HADDR, HTRANS[0]};

  // A lane is enabled when it falls inside the size-aligned block holding the address.
  always_comb begin
    size_mask = '0;
    addr_be   = '0;
    for (int k = 0; k < LBW; k++) size_mask[k] = (int'(HSIZE) > k);
    for (int k = 0; k < NB; k++)
      addr_be[k] = ((LBW'(k) & ~size_mask) == (addr_off & ~size_mask));
  end

  assign accept     = HSEL & HTRANS[1] & HREADY;
  assign rd_present = HSEL & HTRANS[1] & ~HWRITE & size_ok;
  // HREADY is left out of the stall term: it is our own HREADYOUT in this data phase.
  assign stall      = dp_write & wbuf_valid & rd_present;
  assign rd_issue   = accept & ~HWRITE & size_ok & ~stall & ~HRESET;
  assign err_accept = accept & ~size_ok;
  assign wr_done    = dp_write & ~stall;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_write <= 1'b0;
      dp_read  <= 1'b0;
      dp_idx   <= '0;
      dp_be    <= '0;
    end else if (HREADY) begin
      dp_write <= accept & HWRITE & size_ok;
      dp_read  <= rd_issue;
      dp_idx   <= addr_idx;
      dp_be    <= addr_be;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wbuf_valid <= 1'b0;
      wbuf_addr  <= '0;
      wbuf_be    <= '0;
      wbuf_data  <= '0;
    end else if (wr_done) begin
      wbuf_valid <= 1'b1;
      wbuf_addr  <= dp_idx;
      wbuf_be    <= dp_be;
      wbuf_data  <= HWDATA;
    end else if (mem_we) begin
      wbuf_valid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state <= ST_OK;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    HREADYOUT = ~stall;
    HRESP     = 1'b0;
    case (state)
      ST_OK: begin
        if (err_accept) state_nxt = ST_ERR1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP     = 1'b1;
        state_nxt = err_accept ? ST_ERR1 : ST_OK;
      end
      default: state_nxt = ST_OK;
    endcase
  end

  always_comb begin
    HRDATA = '0;
    if (dp_read) begin
      HRDATA = mem_rdata;
      for (int k = 0; k < NB; k++)
        if (wbuf_valid && (wbuf_addr == dp_idx) && wbuf_be[k])
          HRDATA[8*k +: 8] = wbuf_data[8*k +: 8];
    end
  end

  assign mem_re    = rd_issue;
  assign mem_we    = wbuf_valid & ~rd_issue;
  assign mem_addr  = rd_issue ? addr_idx : wbuf_addr;
  assign mem_wdata = wbuf_data;
  assign mem_be    = mem_we ? wbuf_be : '0;

endmodule

// File: tb/tb_ahb_lite_sram_ctrl.sv
// Bench for ahb_lite_sram_ctrl: directed scenarios plus random traffic,
// responses checked by a scoreboard against a program-order memory model.
module tb_ahb_lite_sram_ctrl;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd0;
  logic [31:0] HWDATA = '0;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT, HRESP;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata = '0;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_lite_sram_ctrl #(.HADDR_WIDTH(32), .HDATA_WIDTH(32), .MEM_AW(10)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // SRAM behavioural model; port sampled mid-cycle, applied on the rising edge
  logic [31:0] sram    [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        s_we = 1'b0, s_re = 1'b0;
  logic [9:0]  s_addr;
  logic [3:0]  s_be;
  logic [31:0] s_wd;

  always @(negedge HCLK) begin
    s_we = mem_we; s_re = mem_re; s_addr = mem_addr; s_be = mem_be; s_wd = mem_wdata;
  end

  always @(posedge HCLK) begin
    if (s_re && !HRESET) mem_rdata <= sram[s_addr];
    if (s_we && !HRESET)
      for (int k = 0; k < 4; k++)
        if (s_be[k]) sram[s_addr][8*k +: 8] <= s_wd[8*k +: 8];
  end

  // scoreboard
  typedef struct packed { logic err; logic wr; logic [31:0] data; } exp_t;
  exp_t        sb[$];
  bit          dp_active = 0;
  int          wait_cycles = 0;
  int          stall_cnt = 0;
  logic        stall_we;
  logic [9:0]  stall_addr;

  always @(negedge HCLK) begin
    if (HRESET) begin
      sb.delete();
      dp_active = 0;
      wait_cycles = 0;
    end else begin
      chk("mem_port_onehot", 32'(mem_we & mem_re), 32'd0);
      if (dp_active) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
          dp_active = 0;
        end else if (!HREADYOUT) begin
          wait_cycles++;
          if (sb[0].err) chk("err_first_hresp", 32'(HRESP), 32'd1);
          else begin
            stall_cnt++;
            stall_we   = mem_we;
            stall_addr = mem_addr;
            chk("stall_only_on_write", 32'(sb[0].wr), 32'd1);
            chk("stall_hresp", 32'(HRESP), 32'd0);
          end
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("hresp", 32'(HRESP), 32'(e.err));
          chk("hrdata", HRDATA, (e.err || e.wr) ? 32'd0 : e.data);
          if (e.err) chk("err_wait", 32'(wait_cycles), 32'd1);
          else       chk("okay_wait_le1", (wait_cycles <= 1) ? 32'd0 : 32'(wait_cycles), 32'd0);
          wait_cycles = 0;
        end
      end
      if (HREADYOUT) dp_active = HSEL && HTRANS[1];
    end
  end

  function automatic logic [3:0] calc_be(input logic [31:0] addr, input logic [2:0] size);
    int nbytes, sh;
    nbytes = 1 << size;
    sh     = int'(addr[1:0]) & ~(nbytes - 1);
    return 4'(((1 << nbytes) - 1) << sh);
  endfunction

  logic       saw_re, saw_we;
  logic [9:0] last_addr;
  logic [3:0] last_be;
  logic [31:0] last_wd;
  int         last_n;

  task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, input bit upd_ref);
    logic rdy;
    logic [3:0] be;
    logic [9:0] idx;
    int n;
    n = 0; rdy = 1'b0;
    HSEL = sel; HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
    saw_re = 1'b0; saw_we = 1'b0;
    do begin
      @(negedge HCLK);
      rdy = HREADYOUT;
      saw_re |= mem_re; saw_we |= mem_we;
      last_addr = mem_addr; last_be = mem_be; last_wd = mem_wdata;
      @(posedge HCLK); #1;
      n++;
    end while (!rdy && n < 16);
    last_n = n;
    if (!rdy) chk("xfer_timeout", 32'(n), 32'd0);
    if (rdy && sel && trans[1]) begin
      idx = addr[11:2];
      if (size > 3'd2) sb.push_back('{err: 1'b1, wr: wr, data: 32'd0});
      else if (wr) begin
        be = calc_be(addr, size);
        if (upd_ref)
          for (int k = 0; k < 4; k++)
            if (be[k]) ref_mem[idx][8*k +: 8] = wd[8*k +: 8];
        sb.push_back('{err: 1'b0, wr: 1'b1, data: 32'd0});
        HWDATA = wd;
      end else sb.push_back('{err: 1'b0, wr: 1'b0, data: ref_mem[idx]});
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) xfer(1'b1, 2'b00, 1'b0, 32'd0, 3'd2, 32'd0, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, bad;
    logic [31:0] a, wd;
    logic [2:0] sz;
    logic [1:0] tr;
    logic sel, wr;
    int r;
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = 32'h9E37_79B9 * (i + 1);
      ref_mem[i] = sram[i];
    end
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("rst_hresp",     32'(HRESP), 32'd0);
    chk("rst_hrdata",    HRDATA, 32'd0);
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mem_re",    32'(mem_re), 32'd0);
    chk("rst_mem_be",    32'(mem_be), 32'd0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // 1: plain read of word 0x10
    xfer(1'b1, 2'b10, 1'b0, 32'h40, 3'd2, 32'd0, 1'b1);
    chk("t1_mem_re", 32'(saw_re), 32'd1);
    chk("t1_mem_addr", 32'(last_addr), 32'h10);
    chk("t1_addr_wait", 32'(last_n), 32'd1);
    idle(1);
    chk("t1_data_wait", 32'(last_n), 32'd1);

    // 2: word write then IDLE drains
    xfer(1'b1, 2'b10, 1'b1, 32'h80, 3'd2, 32'hA5A5_A5A5, 1'b1);
    idle(1);
    idle(1);
    chk("t2_mem_we", 32'(saw_we), 32'd1);
    chk("t2_mem_addr", 32'(last_addr), 32'h20);
    chk("t2_mem_be", 32'(last_be), 32'hF);
    chk("t2_mem_wdata", last_wd, 32'hA5A5_A5A5);

    // 3: byte write then back-to-back read of the same word
    s0 = stall_cnt;
    xfer(1'b1, 2'b10, 1'b1, 32'h81, 3'd0, 32'h0000_EE00, 1'b1);
    xfer(1'b1, 2'b10, 1'b0, 32'h80, 3'd2, 32'd0, 1'b1);
    idle(2);
    chk("t3_no_stall", 32'(stall_cnt - s0), 32'd0);
    chk("t3_ref_word", ref_mem[10'h20], 32'hA5A5_EEA5);

    // 4: two writes then a read during the second write's data phase
    s0 = stall_cnt;
    xfer(1'b1, 2'b10, 1'b1, 32'hC0, 3'd2, 32'h1111_1111, 1'b1);
    xfer(1'b1, 2'b11, 1'b1, 32'hC4, 3'd2, 32'h2222_2222, 1'b1);
    xfer(1'b1, 2'b10, 1'b0, 32'h100, 3'd2, 32'd0, 1'b1);
    chk("t4_read_wait", 32'(last_n), 32'd2);
    chk("t4_read_addr", 32'(last_addr), 32'h40);
    idle(3);
    chk("t4_stall_cnt", 32'(stall_cnt - s0), 32'd1);
    chk("t4_stall_we", 32'(stall_we), 32'd1);
    chk("t4_stall_addr", 32'(stall_addr), 32'h30);
    chk("t4_sram_30", sram[10'h30], 32'h1111_1111);
    chk("t4_sram_31", sram[10'h31], 32'h2222_2222);

    // 5: illegal size
    xfer(1'b1, 2'b10, 1'b0, 32'h200, 3'd3, 32'd0, 1'b1);
    chk("t5_addr_mem", 32'({saw_re, saw_we}), 32'd0);
    idle(1);
    chk("t5_data_mem", 32'({saw_re, saw_we}), 32'd0);
    chk("t5_data_wait", 32'(last_n), 32'd2);
    idle(1);

    // 6: reset while the write buffer holds data
    xfer(1'b1, 2'b10, 1'b1, 32'h300, 3'd2, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    #1 HRESET = 1'b1;
    #1;
    chk("t6_mem_we", 32'(mem_we), 32'd0);
    chk("t6_mem_re", 32'(mem_re), 32'd0);
    chk("t6_mem_be", 32'(mem_be), 32'd0);
    chk("t6_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("t6_hresp", 32'(HRESP), 32'd0);
    chk("t6_hrdata", HRDATA, 32'd0);
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    idle(3);
    chk("t6_sram_unwritten", sram[10'hC0], ref_mem[10'hC0]);

    // random traffic over a small window of words to provoke hazards
    for (int it = 0; it < 800; it++) begin
      r   = int'($urandom_range(0, 99));
      tr  = (r < 10) ? 2'b00 : (r < 15) ? 2'b01 : 2'($urandom_range(2, 3));
      sel = ($urandom_range(0, 9) != 0);
      wr  = 1'($urandom_range(0, 1));
      a   = 32'($urandom_range(0, 63));
      sz  = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      wd  = $urandom;
      xfer(sel, tr, wr, a, sz, wd, 1'b1);
    end
    idle(4);

    bad = 0;
    for (int i = 0; i < 1024; i++) if (sram[i] !== ref_mem[i]) bad++;
    chk("final_sram_image", 32'(bad), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
